// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: merges the inst and data SRAM-like master ports onto one
// downstream SRAM-like port. It arbitrates each address phase, holds the grant
// until addr_ok, and keeps an in-order owner FIFO so every data_ok returns to
// the requester that issued it.
// Optional build macro: ARB_RR_EN selects round-robin when both request;
// without it, data has fixed priority over inst.
module sram_like_arbiter #(
   parameter int unsigned OT_DEPTH = 2,
   parameter int unsigned OT_AW    = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic [31:0] inst_rdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic        m_req,
   output logic        m_wr,
   output logic [1:0]  m_size,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,
   input  logic        m_addr_ok,
   input  logic        m_data_ok
);

   localparam int unsigned CW      = OT_AW + 1;
   localparam logic        ID_INST = 1'b0;
   localparam logic        ID_DATA = 1'b1;

   typedef enum logic {ST_UNLOCKED = 1'b0, ST_LOCKED = 1'b1} lock_e;

   lock_e               r_state, w_state_nxt;
   logic                r_owner, w_owner_nxt;
   logic [OT_DEPTH-1:0] r_fifo;
   logic [OT_AW-1:0]    r_wptr, r_rptr;
   logic [CW-1:0]       r_count;
   logic                w_full, w_empty, w_gnt, w_gnt_id, w_push, w_pop, w_head;
   logic                w_owner_req;
`ifdef ARB_RR_EN
   logic                r_rr;
`endif

   function automatic logic [OT_AW-1:0] ptr_inc(input logic [OT_AW-1:0] p);
      return (p == OT_AW'(OT_DEPTH - 1)) ? '0 : p + OT_AW'(1);
   endfunction

   assign w_full      = (r_count == CW'(OT_DEPTH));
   assign w_empty     = (r_count == '0);
   assign w_push      = m_req & m_addr_ok;
   assign w_pop       = m_data_ok & ~w_empty;
   assign w_head      = r_fifo[r_rptr];
   assign w_owner_req = (r_owner == ID_DATA) ? data_req : inst_req;

   // Grant selection: locked owner, else data/inst priority (or round-robin)
   always_comb begin
      w_gnt    = 1'b0;
      w_gnt_id = ID_INST;
      if (!w_full) begin
         if (r_state == ST_LOCKED) begin
            w_gnt_id = r_owner;
            w_gnt    = w_owner_req;
         end else if (data_req && inst_req) begin
            w_gnt = 1'b1;
`ifdef ARB_RR_EN
            w_gnt_id = r_rr;
`else
            w_gnt_id = ID_DATA;
`endif
         end else if (data_req) begin
            w_gnt    = 1'b1;
            w_gnt_id = ID_DATA;
         end else if (inst_req) begin
            w_gnt    = 1'b1;
            w_gnt_id = ID_INST;
         end
      end
   end

   // Request mux toward the downstream port and addr_ok routing back
   always_comb begin
      m_req        = 1'b0;
      m_wr         = 1'b0;
      m_size       = 2'b00;
      m_addr       = '0;
      m_wdata      = '0;
      inst_addr_ok = 1'b0;
      data_addr_ok = 1'b0;
      if (w_gnt) begin
         m_req = 1'b1;
         if (w_gnt_id == ID_DATA) begin
            m_wr         = data_wr;
            m_size       = data_size;
            m_addr       = data_addr;
            m_wdata      = data_wdata;
            data_addr_ok = m_addr_ok;
         end else begin
            m_wr         = inst_wr;
            m_size       = inst_size;
            m_addr       = inst_addr;
            m_wdata      = inst_wdata;
            inst_addr_ok = m_addr_ok;
         end
      end
   end

   // Response routing by FIFO head; a data_ok with nothing outstanding is dropped
   always_comb begin
      inst_data_ok = w_pop & (w_head == ID_INST);
      data_data_ok = w_pop & (w_head == ID_DATA);
      inst_rdata   = inst_data_ok ? m_rdata : '0;
      data_rdata   = data_data_ok ? m_rdata : '0;
   end

   // Lock next-state: hold the grant while a request waits for addr_ok
   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      case (r_state)
         ST_UNLOCKED: begin
            if (m_req && !m_addr_ok) begin
               w_state_nxt = ST_LOCKED;
               w_owner_nxt = w_gnt_id;
            end
         end
         ST_LOCKED: begin
            if (m_addr_ok || !w_owner_req) w_state_nxt = ST_UNLOCKED;
         end
         default: w_state_nxt = ST_UNLOCKED;
      endcase
   end

   // Lock state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_UNLOCKED;
         r_owner <= ID_INST;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
      end
   end

   // Owner FIFO: push on address handshake, pop on returned data
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_fifo  <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_fifo[r_wptr] <= w_gnt_id;
            r_wptr         <= ptr_inc(r_wptr);
         end
         if (w_pop) r_rptr <= ptr_inc(r_rptr);
         if (w_push && !w_pop)      r_count <= r_count + CW'(1);
         else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      end
   end

`ifdef ARB_RR_EN
   // Round-robin pointer: favour the side not served by the last handshake
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)     r_rr <= ID_INST;
      else if (w_push) r_rr <= ~w_gnt_id;
   end
`endif

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Scoreboard bench for sram_like_arbiter: directed stimulus pushes expected
// address handshakes and data returns; a negedge monitor pops and compares.
module tb_sram_like_arbiter;

   typedef struct packed {
      logic        side;
      logic [31:0] addr;
      logic        wr;
      logic [1:0]  size;
      logic [31:0] wdata;
   } a_exp_t;

   typedef struct packed {
      logic        side;
      logic [31:0] rdata;
   } d_exp_t;

`ifdef ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_req, inst_wr, data_req, data_wr;
   logic [1:0]  inst_size, data_size, m_size;
   logic [31:0] inst_addr, inst_wdata, inst_rdata, data_addr, data_wdata, data_rdata;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic        m_req, m_wr, m_addr_ok, m_data_ok;
   logic [31:0] m_addr, m_wdata, m_rdata;

   a_exp_t exp_a[$];
   d_exp_t exp_d[$];
   int     n_chk  = 0;
   int     n_fail = 0;

   sram_like_arbiter #(.OT_DEPTH(2), .OT_AW(1)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
      .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_rdata(m_rdata), .m_addr_ok(m_addr_ok),
      .m_data_ok(m_data_ok)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_a(input logic side, input logic [31:0] addr, input logic wr,
                         input logic [1:0] size, input logic [31:0] wdata);
      a_exp_t e;
      e.side = side; e.addr = addr; e.wr = wr; e.size = size; e.wdata = wdata;
      exp_a.push_back(e);
   endtask

   task automatic ret(input logic side, input logic [31:0] rdata);
      d_exp_t e;
      e.side = side; e.rdata = rdata;
      exp_d.push_back(e);
      m_data_ok = 1'b1;
      m_rdata   = rdata;
      tick();
      m_data_ok = 1'b0;
      m_rdata   = '0;
   endtask

   task automatic idle();
      inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = '0; inst_wdata = '0;
      data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = '0; data_wdata = '0;
      m_addr_ok = 0; m_data_ok = 0; m_rdata = '0;
   endtask

   // Monitor: compare every handshake the DUT presents against the scoreboard
   initial begin
      a_exp_t ea;
      d_exp_t ed;
      forever begin
         @(negedge clk);
         if (resetn) begin
            if (m_req && m_addr_ok) begin
               if (exp_a.size() == 0) begin
                  chk("unexpected_addr_hs", {m_addr, m_wr, m_size}, '0);
               end else begin
                  ea = exp_a.pop_front();
                  chk("addr_hs", {inst_addr_ok, data_addr_ok, m_addr, m_wr, m_size, m_wdata},
                      {~ea.side, ea.side, ea.addr, ea.wr, ea.size, ea.wdata});
               end
            end
            if (inst_data_ok || data_data_ok) begin
               if (exp_d.size() == 0) begin
                  chk("unexpected_data_ok", {inst_data_ok, data_data_ok}, '0);
               end else begin
                  ed = exp_d.pop_front();
                  if (ed.side)
                     chk("data_ok", {inst_data_ok, data_data_ok, inst_rdata, data_rdata},
                         {1'b0, 1'b1, 32'h0, ed.rdata});
                  else
                     chk("data_ok", {inst_data_ok, data_data_ok, inst_rdata, data_rdata},
                         {1'b1, 1'b0, ed.rdata, 32'h0});
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic s0, s1;
      resetn = 1'b0;
      idle();
      // Reset: all outputs zero, a stray data_ok produces nothing
      m_data_ok = 1'b1;
      m_rdata   = 32'h1111_2222;
      @(negedge clk);
      chk("rst_mport", {m_req, m_wr, m_size, m_addr, m_wdata}, '0);
      chk("rst_oks", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, '0);
      chk("rst_rdata", {inst_rdata, data_rdata}, '0);
      tick();
      idle();
      resetn = 1'b1;
      tick();

      // Single inst read with pass-through response
      inst_req = 1; inst_addr = 32'hBFC0_0000; m_addr_ok = 1;
      push_a(0, 32'hBFC0_0000, 0, 2'd2, 32'h0);
      @(negedge clk);
      chk("t1_addr_ok", {m_addr, inst_addr_ok, data_addr_ok}, {32'hBFC0_0000, 1'b1, 1'b0});
      tick();
      inst_req = 0; m_addr_ok = 0;
      tick();
      ret(0, 32'h3C1D_BFC0);

      // Simultaneous requests: data first, then inst; in-order returns
      data_req = 1; data_addr = 32'h8000_0010; data_wr = 1; data_wdata = 32'h1234_5678;
      inst_req = 1; inst_addr = 32'hBFC0_0004; m_addr_ok = 1;
      push_a(1, 32'h8000_0010, 1, 2'd2, 32'h1234_5678);
      push_a(0, 32'hBFC0_0004, 0, 2'd2, 32'h0);
      tick();
      data_req = 0; data_wr = 0; data_wdata = '0;
      tick();
      inst_req = 0; m_addr_ok = 0;
      ret(1, 32'hAAAA_0001);
      ret(0, 32'hBBBB_0002);

      // Data held off three cycles; inst raised meanwhile must wait
      data_req = 1; data_addr = 32'h8000_0020;
      @(negedge clk);
      chk("t3_lock_c1", {m_req, m_addr, inst_addr_ok, data_addr_ok}, {1'b1, 32'h8000_0020, 2'b00});
      tick();
      inst_req = 1; inst_addr = 32'hBFC0_0008;
      @(negedge clk);
      chk("t3_lock_c2", {m_req, m_addr, inst_addr_ok}, {1'b1, 32'h8000_0020, 1'b0});
      tick();
      @(negedge clk);
      chk("t3_lock_c3", {m_req, m_addr, inst_addr_ok}, {1'b1, 32'h8000_0020, 1'b0});
      tick();
      m_addr_ok = 1;
      push_a(1, 32'h8000_0020, 0, 2'd2, 32'h0);
      push_a(0, 32'hBFC0_0008, 0, 2'd2, 32'h0);
      tick();
      data_req = 0;
      tick();
      inst_req = 0; m_addr_ok = 0;
      ret(1, 32'hCCCC_0003);
      ret(0, 32'hDDDD_0004);

      // Inst locks first; a later data request may not steal the grant
      inst_req = 1; inst_addr = 32'hBFC0_000C;
      @(negedge clk);
      chk("t3b_lock_c1", {m_req, m_addr}, {1'b1, 32'hBFC0_000C});
      tick();
      data_req = 1; data_addr = 32'h8000_0030;
      @(negedge clk);
      chk("t3b_lock_c2", {m_req, m_addr, data_addr_ok}, {1'b1, 32'hBFC0_000C, 1'b0});
      tick();
      m_addr_ok = 1;
      push_a(0, 32'hBFC0_000C, 0, 2'd2, 32'h0);
      push_a(1, 32'h8000_0030, 0, 2'd2, 32'h0);
      tick();
      inst_req = 0;
      tick();
      data_req = 0; m_addr_ok = 0;
      ret(0, 32'hEEEE_0005);
      ret(1, 32'hFFFF_0006);

      // Outstanding limit: third inst blocked until a pop, no same-cycle bypass
      inst_req = 1; inst_addr = 32'hBFC0_00C0; m_addr_ok = 1;
      push_a(0, 32'hBFC0_00C0, 0, 2'd2, 32'h0);
      tick();
      inst_addr = 32'hBFC0_00C4;
      push_a(0, 32'hBFC0_00C4, 0, 2'd2, 32'h0);
      tick();
      inst_addr = 32'hBFC0_00C8;
      @(negedge clk);
      chk("t4_full_c1", {m_req, inst_addr_ok}, 2'b00);
      tick();
      @(negedge clk);
      chk("t4_full_c2", {m_req, inst_addr_ok}, 2'b00);
      tick();
      m_data_ok = 1; m_rdata = 32'h0101_0101;
      exp_d.push_back('{side: 1'b0, rdata: 32'h0101_0101});
      @(negedge clk);
      chk("t4_no_bypass", {m_req, inst_addr_ok}, 2'b00);
      tick();
      m_data_ok = 0; m_rdata = '0;
      push_a(0, 32'hBFC0_00C8, 0, 2'd2, 32'h0);
      @(negedge clk);
      chk("t4_reissue", {m_req, inst_addr_ok, m_addr}, {2'b11, 32'hBFC0_00C8});
      tick();
      inst_req = 0; m_addr_ok = 0;
      ret(0, 32'h0202_0202);
      ret(0, 32'h0303_0303);

      // data_ok with nothing outstanding is ignored
      m_data_ok = 1; m_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("t5_empty_dok", {inst_data_ok, data_data_ok, inst_rdata, data_rdata}, '0);
      tick();
      m_data_ok = 0; m_rdata = '0;

      // Reset with two outstanding: later data_ok dropped, grant immediate
      data_req = 1; data_addr = 32'h8000_0040;
      inst_req = 1; inst_addr = 32'hBFC0_0040; m_addr_ok = 1;
      push_a(1, 32'h8000_0040, 0, 2'd2, 32'h0);
      push_a(0, 32'hBFC0_0040, 0, 2'd2, 32'h0);
      tick();
      data_req = 0;
      tick();
      idle();
      resetn = 0;
      m_data_ok = 1; m_rdata = 32'h5555_AAAA;
      @(negedge clk);
      chk("t5_rst_out", {m_req, m_addr, inst_data_ok, data_data_ok, inst_rdata, data_rdata}, '0);
      tick();
      resetn = 1;
      @(negedge clk);
      chk("t5_late_dok", {inst_data_ok, data_data_ok, inst_rdata, data_rdata}, '0);
      tick();
      m_data_ok = 0; m_rdata = '0;
      inst_req = 1; inst_addr = 32'hBFC0_0050; m_addr_ok = 1;
      push_a(0, 32'hBFC0_0050, 0, 2'd2, 32'h0);
      @(negedge clk);
      chk("t5_post_rst_gnt", {m_req, inst_addr_ok}, 2'b11);
      tick();
      inst_req = 0; m_addr_ok = 0;
      ret(0, 32'h0505_0505);

      // Both held high: alternate with round-robin, data always otherwise
      for (int round = 0; round < 2; round++) begin
         s0 = 1'b1;
         s1 = RR ? 1'b0 : 1'b1;
         inst_req = 1; inst_addr = 32'hBFC0_0100;
         data_req = 1; data_addr = 32'h8000_0100; m_addr_ok = 1;
         push_a(s0, s0 ? 32'h8000_0100 : 32'hBFC0_0100, 0, 2'd2, 32'h0);
         push_a(s1, s1 ? 32'h8000_0100 : 32'hBFC0_0100, 0, 2'd2, 32'h0);
         tick();
         tick();
         inst_req = 0; data_req = 0; m_addr_ok = 0;
         ret(s0, 32'h6000_0000 + 32'(round));
         ret(s1, 32'h7000_0000 + 32'(round));
      end

      tick();
      chk("scoreboard_drained", {32'(exp_a.size()), 32'(exp_d.size())}, '0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
